dmem_arb: RTL and testbench

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arb_rr_arb2.sv | 48 ++++
 rtl/dmem_arb.sv | 105 ++++++++++
 tb/tb_dmem_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared owner encoding and default widths for dmem_arb
package dmem_arb_pkg;

  localparam int DEF_ADDRW = 32;
  localparam int DEF_DATAW = 32;

  // Which requester owns the shared data-memory port
  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// rtl/dmem_arb_rr_arb2.sv - two-input round-robin arbiter with registered priority pointer
module dmem_arb_rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic cpu_req_i,
  input  logic host_req_i,
  output logic cpu_gnt_o,
  output logic host_gnt_o
);

  // prio_q names the requester that wins the next contended cycle
  owner_e prio_q, prio_d;

  // On contention the pointer moves to the loser so it wins next time
  always_comb begin
    prio_d = prio_q;
    if (cpu_req_i && host_req_i) begin
      prio_d = (prio_q == OWN_CPU) ? OWN_HOST : OWN_CPU;
    end
  end

  // Pointer register; reset makes the CPU win the first contention
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_q <= OWN_CPU;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Grants: lone requester passes straight through, contention follows the pointer
  always_comb begin
    cpu_gnt_o  = 1'b0;
    host_gnt_o = 1'b0;
    if (!reset_i) begin
      if (cpu_req_i && host_req_i) begin
        cpu_gnt_o  = (prio_q == OWN_CPU);
        host_gnt_o = (prio_q == OWN_HOST);
      end else begin
        cpu_gnt_o  = cpu_req_i;
        host_gnt_o = host_req_i;
      end
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - CPU/host arbiter for a single shared data-memory port
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int ADDRW = DEF_ADDRW,
  parameter int DATAW = DEF_DATAW
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [ADDRW-1:0]   cpu_rd_addr_i,
  input  logic               cpu_rd_req_i,
  input  logic [ADDRW-1:0]   cpu_wr_addr_i,
  input  logic [DATAW-1:0]   cpu_wr_data_i,
  input  logic [DATAW/8-1:0] cpu_wr_be_i,
  input  logic               cpu_wr_req_i,
  output logic               cpu_stall_o,
  output logic [DATAW-1:0]   cpu_rd_data_o,
  input  logic               host_req_i,
  input  logic               host_we_i,
  input  logic [ADDRW-1:0]   host_addr_i,
  input  logic [DATAW-1:0]   host_wr_data_i,
  input  logic [DATAW/8-1:0] host_be_i,
  output logic               host_ack_o,
  output logic               host_rd_valid_o,
  output logic [DATAW-1:0]   host_rd_data_o,
  output logic [ADDRW-1:0]   mem_rd_addr_o,
  output logic               mem_rd_req_o,
  output logic [ADDRW-1:0]   mem_wr_addr_o,
  output logic [DATAW-1:0]   mem_wr_data_o,
  output logic [DATAW/8-1:0] mem_wr_be_o,
  output logic               mem_wr_req_o,
  input  logic [DATAW-1:0]   mem_rd_data_i
);

  logic   cpu_acc;
  logic   cpu_gnt;
  logic   host_gnt;
  logic   rd_vld_q, rd_vld_d;
  owner_e own_q, own_d;

  // A CPU load and store in the same cycle compete as one access
  assign cpu_acc = cpu_rd_req_i | cpu_wr_req_i;

  dmem_arb_rr_arb2 u_rr_arb2 (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .cpu_req_i  (cpu_acc),
    .host_req_i (host_req_i),
    .cpu_gnt_o  (cpu_gnt),
    .host_gnt_o (host_gnt)
  );

  // Memory port mux: only the owner's signals are passed, idle drives zeros
  always_comb begin
    mem_rd_addr_o = '0;
    mem_wr_addr_o = '0;
    mem_wr_data_o = '0;
    mem_wr_be_o   = '0;
    mem_rd_req_o  = 1'b0;
    mem_wr_req_o  = 1'b0;
    if (cpu_gnt) begin
      mem_rd_addr_o = cpu_rd_addr_i;
      mem_rd_req_o  = cpu_rd_req_i;
      mem_wr_addr_o = cpu_wr_addr_i;
      mem_wr_data_o = cpu_wr_data_i;
      mem_wr_be_o   = cpu_wr_be_i;
      mem_wr_req_o  = cpu_wr_req_i;
    end else if (host_gnt) begin
      mem_rd_addr_o = host_addr_i;
      mem_wr_addr_o = host_addr_i;
      mem_wr_data_o = host_wr_data_i;
      mem_wr_be_o   = host_be_i;
      mem_rd_req_o  = !host_we_i;
      mem_wr_req_o  = host_we_i;
    end
  end

  assign cpu_stall_o = cpu_acc && !cpu_gnt && !reset_i;
  assign host_ack_o  = host_gnt;

  // Remember whether a read went out this cycle and for whom
  always_comb begin
    rd_vld_d = mem_rd_req_o;
    own_d    = host_gnt ? OWN_HOST : OWN_CPU;
  end

  // Read-return owner flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_vld_q <= 1'b0;
      own_q    <= OWN_CPU;
    end else begin
      rd_vld_q <= rd_vld_d;
      own_q    <= own_d;
    end
  end

  // Route returning read data; reset suppresses an in-flight host return
  always_comb begin
    host_rd_valid_o = rd_vld_q && (own_q == OWN_HOST) && !reset_i;
    host_rd_data_o  = host_rd_valid_o ? mem_rd_data_i : '0;
    cpu_rd_data_o   = (rd_vld_q && (own_q == OWN_CPU)) ? mem_rd_data_i : '0;
  end

endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - randomized self-checking bench for dmem_arb against a reference model
module tb_dmem_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_rd_addr;
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_wr_data;
  logic [BW-1:0] cpu_wr_be;
  logic          cpu_wr_req;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rd_data;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wr_data;
  logic [BW-1:0] host_be;
  logic          host_ack;
  logic          host_rd_valid;
  logic [DW-1:0] host_rd_data;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_req;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [BW-1:0] mem_wr_be;
  logic          mem_wr_req;
  logic [DW-1:0] mem_rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arb #(.ADDRW(AW), .DATAW(DW)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .cpu_rd_addr_i   (cpu_rd_addr),
    .cpu_rd_req_i    (cpu_rd_req),
    .cpu_wr_addr_i   (cpu_wr_addr),
    .cpu_wr_data_i   (cpu_wr_data),
    .cpu_wr_be_i     (cpu_wr_be),
    .cpu_wr_req_i    (cpu_wr_req),
    .cpu_stall_o     (cpu_stall),
    .cpu_rd_data_o   (cpu_rd_data),
    .host_req_i      (host_req),
    .host_we_i       (host_we),
    .host_addr_i     (host_addr),
    .host_wr_data_i  (host_wr_data),
    .host_be_i       (host_be),
    .host_ack_o      (host_ack),
    .host_rd_valid_o (host_rd_valid),
    .host_rd_data_o  (host_rd_data),
    .mem_rd_addr_o   (mem_rd_addr),
    .mem_rd_req_o    (mem_rd_req),
    .mem_wr_addr_o   (mem_wr_addr),
    .mem_wr_data_o   (mem_wr_data),
    .mem_wr_be_o     (mem_wr_be),
    .mem_wr_req_o    (mem_wr_req),
    .mem_rd_data_i   (mem_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Environment memory: 16 words, one-cycle read latency, read returns pre-write data
  logic [DW-1:0] mem [16];
  bit            mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (mem_rd_req) mem_rd_data <= mem[mem_rd_addr[5:2]];
      if (mem_wr_req) mem[mem_wr_addr[5:2]] <= merge(mem[mem_wr_addr[5:2]], mem_wr_data, mem_wr_be);
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [16];
  bit            last_winner_host;
  bit            pend_cpu, pend_host;
  logic [DW-1:0] pend_data;
  bit            last_cg, last_hg, last_stall;
  int            host_wait, max_host_wait;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: check outputs at the negedge against the model, then advance the model
  task automatic cycle();
    bit ca, cg, hg;
    @(negedge clk);
    ca = cpu_rd_req || cpu_wr_req;
    cg = 1'b0;
    hg = 1'b0;
    if (!reset) begin
      if (ca && host_req) begin
        cg = last_winner_host;
        hg = !last_winner_host;
      end else begin
        cg = ca;
        hg = host_req;
      end
    end
    chk("cpu_stall", cpu_stall, ca && !cg && !reset);
    chk("host_ack", host_ack, hg);
    chk("mem_rd_req", mem_rd_req, (cg && cpu_rd_req) || (hg && !host_we));
    chk("mem_wr_req", mem_wr_req, (cg && cpu_wr_req) || (hg && host_we));
    if (cg && cpu_rd_req) chk("cpu_rd_addr", mem_rd_addr, cpu_rd_addr);
    if (cg && cpu_wr_req) begin
      chk("cpu_wr_addr", mem_wr_addr, cpu_wr_addr);
      chk("cpu_wr_data", mem_wr_data, cpu_wr_data);
      chk("cpu_wr_be", mem_wr_be, cpu_wr_be);
    end
    if (hg && host_we) begin
      chk("host_wr_addr", mem_wr_addr, host_addr);
      chk("host_wr_data", mem_wr_data, host_wr_data);
      chk("host_wr_be", mem_wr_be, host_be);
    end
    if (hg && !host_we) chk("host_rd_addr", mem_rd_addr, host_addr);
    chk("host_rd_valid", host_rd_valid, pend_host && !reset);
    chk("host_rd_data", host_rd_data, (pend_host && !reset) ? pend_data : '0);
    if (pend_cpu) chk("cpu_rd_data", cpu_rd_data, pend_data);

    if (reset || !host_req || hg) host_wait = 0;
    else host_wait++;
    if (host_wait > max_host_wait) max_host_wait = host_wait;

    pend_cpu  = cg && cpu_rd_req;
    pend_host = hg && !host_we;
    if (pend_cpu)  pend_data = ref_mem[cpu_rd_addr[5:2]];
    if (pend_host) pend_data = ref_mem[host_addr[5:2]];
    if (cg && cpu_wr_req) ref_mem[cpu_wr_addr[5:2]] = merge(ref_mem[cpu_wr_addr[5:2]], cpu_wr_data, cpu_wr_be);
    if (hg && host_we)    ref_mem[host_addr[5:2]]   = merge(ref_mem[host_addr[5:2]], host_wr_data, host_be);
    if (reset) last_winner_host = 1'b1;
    else if (ca && host_req) last_winner_host = hg;
    last_cg    = cg;
    last_hg    = hg;
    last_stall = ca && !cg && !reset;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit rd, input logic [AW-1:0] ra, input bit wr,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [BW-1:0] be);
    cpu_rd_req  = rd;
    cpu_rd_addr = ra;
    cpu_wr_req  = wr;
    cpu_wr_addr = wa;
    cpu_wr_data = wd;
    cpu_wr_be   = be;
  endtask

  task automatic set_host(input bit req, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
    host_req     = req;
    host_we      = we;
    host_addr    = a;
    host_wr_data = d;
    host_be      = be;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    last_winner_host = 1'b1;
    pend_cpu  = 1'b0;
    pend_host = 1'b0;
    pend_data = '0;
    host_wait = 0;
    max_host_wait = 0;
    reset = 1'b1;
    set_cpu(1'b1, 32'h10, 1'b1, 32'h14, 32'h0, 4'hF);
    set_host(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    cycle();
    cycle();
    reset = 1'b0;
    set_cpu(1'b0, '0, 1'b0, '0, '0, '0);
    set_host(1'b0, 1'b0, '0, '0, '0);
    cycle();

    // CPU-only load from 0x10
    set_cpu(1'b1, 32'h10, 1'b0, '0, '0, '0);
    cycle();
    set_cpu(1'b0, '0, 1'b0, '0, '0, '0);
    cycle();

    // Host write then read of 0x20, then idle to see the return
    set_host(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF);
    cycle();
    set_host(1'b1, 1'b0, 32'h20, '0, '0);
    cycle();
    set_host(1'b0, 1'b0, '0, '0, '0);
    cycle();
    chk("deadbeef_readback", ref_mem[8], 32'hDEAD_BEEF);

    // Contention from reset: CPU, HOST, CPU, HOST
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_cpu(1'b1, 32'h04, 1'b0, '0, '0, '0);
    set_host(1'b1, 1'b0, 32'h08, '0, '0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_order_cpu", last_cg, (k % 2) == 0);
    end

    // CPU load+store together against a contending host
    set_cpu(1'b1, 32'h0C, 1'b1, 32'h30, 32'h0BAD_F00D, 4'h5);
    set_host(1'b1, 1'b1, 32'h34, 32'hCAFE_0001, 4'hA);
    cycle();
    cycle();
    set_cpu(1'b0, '0, 1'b0, '0, '0, '0);
    set_host(1'b0, 1'b0, '0, '0, '0);
    cycle();

    // Reset right after a host read ack kills the return and rewinds the pointer
    set_host(1'b1, 1'b0, 32'h20, '0, '0);
    cycle();
    set_host(1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_cpu(1'b1, 32'h00, 1'b0, '0, '0, '0);
    set_host(1'b1, 1'b0, 32'h20, '0, '0);
    cycle();
    chk("post_reset_cpu_first", last_cg, 1'b1);

    // Random mix obeying the hold rules
    for (int n = 0; n < 10000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!last_stall)
        set_cpu(1'($urandom), $urandom, 1'($urandom), $urandom, $urandom, 4'($urandom));
      if (!host_req || last_hg)
        set_host(1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
      cycle();
    end
    chk("host_starvation", max_host_wait <= 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
